reg_file_32x64: RTL and testbench

- 32-entry general-purpose register file for the pipelined CPU.
- Written by the writeback stage at the clock edge.
- Read combinationally by the decode stage through two independent 32:1 read-select trees, each built from 8:1 and 4:1 mux cells.
- Register 31 is hardwired to zero (XZR).

---
 rtl/reg_file_32x64.sv | 120 ++++++++++++
 tb/tb_reg_file_32x64.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_32x64.sv
// reg_file_32x64: 32 x DATA_WIDTH general-purpose register file.
//   Register ZERO_REG (31) has no storage and always reads zero.
//   One synchronous write port, two independent combinational read ports.
//   Each read port is a 32:1 select tree: four 8:1 cells feeding one 4:1 cell.
//
// Ports:
//   clk         system clock, writes on rising edge
//   reset       asynchronous active-high clear of every register
//   reg_write   write enable
//   write_reg   destination index
//   write_data  value to write
//   read_reg1/2 source indices
//   read_data1/2 combinational read data
//
// Optional build macro: REG_FILE_BYPASS_EN
//   When defined, a write presented this cycle to the address being read is
//   forwarded combinationally to that read port (suppressed during reset).

module reg_file_32x64 #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned NUM_REGS   = 32,
   parameter int unsigned ZERO_REG   = 31
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  reg_write,
   input  logic [4:0]            write_reg,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic [4:0]            read_reg1,
   input  logic [4:0]            read_reg2,
   output logic [DATA_WIDTH-1:0] read_data1,
   output logic [DATA_WIDTH-1:0] read_data2
);

   localparam int unsigned ADDR_W     = 5;
   localparam int unsigned GROUP_SIZE = 8;
   localparam int unsigned NUM_GROUPS = NUM_REGS / GROUP_SIZE;
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

   // Flattened view of every register output, slot ZERO_REG tied to zero.
   logic [NUM_REGS-1:0][DATA_WIDTH-1:0] reg_q;

   // Storage: one enabled flop bank per writable register.
   for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      if (i == ZERO_REG) begin : g_zero
         assign reg_q[i] = '0;
      end else begin : g_store
         logic                  we_c;
         logic [DATA_WIDTH-1:0] q;

         // One-hot decode slice for this register, gated by reg_write.
         assign we_c = reg_write && (write_reg == ADDR_W'(i));

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               q <= '0;
            end else if (we_c) begin
               q <= write_data;
            end
         end

         assign reg_q[i] = q;
      end
   end

   // 8:1 mux cell.
   function automatic logic [DATA_WIDTH-1:0] mux8(
      input logic [GROUP_SIZE-1:0][DATA_WIDTH-1:0] d,
      input logic [2:0]                            s
   );
      return d[s];
   endfunction

   // 4:1 mux cell.
   function automatic logic [DATA_WIDTH-1:0] mux4(
      input logic [NUM_GROUPS-1:0][DATA_WIDTH-1:0] d,
      input logic [1:0]                            s
   );
      return d[s];
   endfunction

   // 32:1 tree: low address bits pick within a group, high bits pick the group.
   function automatic logic [DATA_WIDTH-1:0] read_tree(
      input logic [NUM_REGS-1:0][DATA_WIDTH-1:0] q,
      input logic [ADDR_W-1:0]                   a
   );
      logic [NUM_GROUPS-1:0][DATA_WIDTH-1:0] grp;
      for (int g = 0; g < int'(NUM_GROUPS); g++) begin
         grp[g] = mux8(q[g*GROUP_SIZE +: GROUP_SIZE], a[2:0]);
      end
      return mux4(grp, a[4:3]);
   endfunction

   logic [DATA_WIDTH-1:0] rd1_c;
   logic [DATA_WIDTH-1:0] rd2_c;

   // Read trees; an unknown select only affects its own port.
   always_comb begin
      rd1_c = read_tree(reg_q, read_reg1);
      rd2_c = read_tree(reg_q, read_reg2);
   end

`ifdef REG_FILE_BYPASS_EN
   logic wr_live_c;
   logic byp1_c;
   logic byp2_c;

   // A live write is one that will land at the next edge.
   assign wr_live_c = !reset && reg_write && (write_reg != ZERO_ADDR);
   assign byp1_c    = wr_live_c && (write_reg == read_reg1);
   assign byp2_c    = wr_live_c && (write_reg == read_reg2);

   assign read_data1 = byp1_c ? write_data : rd1_c;
   assign read_data2 = byp2_c ? write_data : rd2_c;
`else
   assign read_data1 = rd1_c;
   assign read_data2 = rd2_c;
`endif

endmodule

// File: tb/tb_reg_file_32x64.sv
module tb_reg_file_32x64;

   localparam int unsigned W = 64;
`ifdef REG_FILE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic         reg_write;
   logic [4:0]   write_reg;
   logic [W-1:0] write_data;
   logic [4:0]   read_reg1;
   logic [4:0]   read_reg2;
   logic [W-1:0] read_data1;
   logic [W-1:0] read_data2;

   int n_cmp = 0;
   int n_err = 0;

   // Reference: architectural register contents, index 31 never written.
   logic [W-1:0] model [32];

   always #5 clk = ~clk;

   reg_file_32x64 dut (
      .clk        (clk),
      .reset      (reset),
      .reg_write  (reg_write),
      .write_reg  (write_reg),
      .write_data (write_data),
      .read_reg1  (read_reg1),
      .read_reg2  (read_reg2),
      .read_data1 (read_data1),
      .read_data2 (read_data2)
   );

   function automatic logic [W-1:0] ref_read(input logic [4:0] a);
      if (a == 5'd31) return '0;
      return model[a];
   endfunction

   // Expected combinational read including a possible forwarded write.
   function automatic logic [W-1:0] ref_port(input logic [4:0] a);
      if (BYPASS && !reset && reg_write && write_reg != 5'd31 && write_reg == a)
         return write_data;
      return ref_read(a);
   endfunction

   // Drive one write; returns at posedge+1 with reg_write low again.
   task automatic do_write(input logic [4:0] a, input logic [W-1:0] d);
      reg_write  = 1'b1;
      write_reg  = a;
      write_data = d;
      @(posedge clk);
      if (!reset && a != 5'd31) model[a] = d;
      #1;
      reg_write = 1'b0;
   endtask

   task automatic test_reset;
      for (int i = 0; i < 6; i++) do_write(5'($urandom_range(0, 30)), {$urandom, $urandom});
      #2;
      reset = 1'b1;
      for (int i = 0; i < 32; i++) model[i] = '0;
      for (int a = 0; a < 32; a++) begin
         read_reg1 = 5'(a);
         read_reg2 = 5'(31 - a);
         #1;
         n_cmp++;
         if (read_data1 !== '0) begin
            n_err++;
            $display("FAIL reset_rd1 addr=%0d got=%h exp=0", a, read_data1);
         end
         n_cmp++;
         if (read_data2 !== '0) begin
            n_err++;
            $display("FAIL reset_rd2 addr=%0d got=%h exp=0", 31 - a, read_data2);
         end
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_write_read;
      do_write(5'd5, 64'h0123456789ABCDEF);
      do_write(5'd30, 64'hFFFFFFFFFFFFFFFF);
      read_reg1 = 5'd5;
      read_reg2 = 5'd30;
      #1;
      n_cmp++;
      if (read_data1 !== 64'h0123456789ABCDEF) begin
         n_err++;
         $display("FAIL wr_rd_reg5 got=%h exp=%h", read_data1, 64'h0123456789ABCDEF);
      end
      n_cmp++;
      if (read_data2 !== 64'hFFFFFFFFFFFFFFFF) begin
         n_err++;
         $display("FAIL wr_rd_reg30 got=%h exp=%h", read_data2, 64'hFFFFFFFFFFFFFFFF);
      end
   endtask

   task automatic test_zero_reg;
      do_write(5'd31, 64'hDEADBEEF);
      read_reg1 = 5'd31;
      read_reg2 = 5'd31;
      #1;
      n_cmp++;
      if (read_data1 !== '0) begin
         n_err++;
         $display("FAIL zero_reg_rd1 got=%h exp=0", read_data1);
      end
      n_cmp++;
      if (read_data2 !== '0) begin
         n_err++;
         $display("FAIL zero_reg_rd2 got=%h exp=0", read_data2);
      end
   endtask

   task automatic test_enable_low;
      do_write(5'd7, 64'h55);
      reg_write  = 1'b0;
      write_reg  = 5'd7;
      write_data = 64'hAA;
      @(posedge clk);
      #1;
      read_reg1 = 5'd7;
      read_reg2 = 5'd7;
      #1;
      n_cmp++;
      if (read_data1 !== 64'h55) begin
         n_err++;
         $display("FAIL enable_low got=%h exp=%h", read_data1, 64'h55);
      end
   endtask

   task automatic test_same_cycle;
      logic [W-1:0] exp_pre;
      do_write(5'd3, 64'h10);
      read_reg1  = 5'd3;
      read_reg2  = 5'd3;
      reg_write  = 1'b1;
      write_reg  = 5'd3;
      write_data = 64'h20;
      exp_pre    = BYPASS ? 64'h20 : 64'h10;
      #2;
      n_cmp++;
      if (read_data1 !== exp_pre) begin
         n_err++;
         $display("FAIL same_cycle_pre_rd1 got=%h exp=%h", read_data1, exp_pre);
      end
      n_cmp++;
      if (read_data2 !== exp_pre) begin
         n_err++;
         $display("FAIL same_cycle_pre_rd2 got=%h exp=%h", read_data2, exp_pre);
      end
      @(posedge clk);
      model[3] = 64'h20;
      #1;
      reg_write = 1'b0;
      #1;
      n_cmp++;
      if (read_data1 !== 64'h20) begin
         n_err++;
         $display("FAIL same_cycle_post_rd1 got=%h exp=%h", read_data1, 64'h20);
      end
      n_cmp++;
      if (read_data2 !== 64'h20) begin
         n_err++;
         $display("FAIL same_cycle_post_rd2 got=%h exp=%h", read_data2, 64'h20);
      end
   endtask

   task automatic test_random;
      logic [W-1:0] e1;
      logic [W-1:0] e2;
      for (int it = 0; it < 400; it++) begin
         reg_write  = 1'($urandom_range(0, 1));
         write_reg  = 5'($urandom);
         write_data = {$urandom, $urandom};
         read_reg1  = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom);
         read_reg2  = 5'($urandom);
         #3;
         e1 = ref_port(read_reg1);
         e2 = ref_port(read_reg2);
         n_cmp++;
         if (read_data1 !== e1) begin
            n_err++;
            $display("FAIL rand_rd1 it=%0d addr=%0d got=%h exp=%h", it, read_reg1, read_data1, e1);
         end
         n_cmp++;
         if (read_data2 !== e2) begin
            n_err++;
            $display("FAIL rand_rd2 it=%0d addr=%0d got=%h exp=%h", it, read_reg2, read_data2, e2);
         end
         @(posedge clk);
         if (reg_write && write_reg != 5'd31) model[write_reg] = write_data;
         #1;
      end
      reg_write = 1'b0;
      // Full sweep of stored contents after the random traffic.
      for (int a = 0; a < 32; a++) begin
         read_reg1 = 5'(a);
         read_reg2 = 5'(a);
         #1;
         n_cmp++;
         if (read_data1 !== ref_read(5'(a)) || read_data2 !== ref_read(5'(a))) begin
            n_err++;
            $display("FAIL rand_sweep addr=%0d got=%h/%h exp=%h", a, read_data1, read_data2, ref_read(5'(a)));
         end
      end
   endtask

   task automatic test_reset_mid;
      for (int a = 0; a < 31; a++) do_write(5'(a), W'(a));
      read_reg1  = 5'd4;
      read_reg2  = 5'd9;
      #1;
      n_cmp++;
      if (read_data2 !== 64'd9) begin
         n_err++;
         $display("FAIL preload_reg9 got=%h exp=%h", read_data2, 64'd9);
      end
      reg_write  = 1'b1;
      write_reg  = 5'd4;
      write_data = 64'h99;
      reset      = 1'b1;
      #1;
      n_cmp++;
      if (read_data1 !== '0) begin
         n_err++;
         $display("FAIL reset_pulse_reg4 got=%h exp=0", read_data1);
      end
      reset     = 1'b0;
      reg_write = 1'b0;
      for (int i = 0; i < 32; i++) model[i] = '0;
      for (int a = 0; a < 32; a++) begin
         read_reg1 = 5'(a);
         read_reg2 = 5'(31 - a);
         #1;
         n_cmp++;
         if (read_data1 !== '0 || read_data2 !== '0) begin
            n_err++;
            $display("FAIL reset_mid addr=%0d got=%h/%h exp=0", a, read_data1, read_data2);
         end
      end
   endtask

   initial begin
      reset      = 1'b1;
      reg_write  = 1'b0;
      write_reg  = '0;
      write_data = '0;
      read_reg1  = '0;
      read_reg2  = '0;
      for (int i = 0; i < 32; i++) model[i] = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      test_reset();
      test_write_read();
      test_zero_reg();
      test_enable_low();
      test_same_cycle();
      test_random();
      test_reset_mid();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
